icache: RTL and testbench

Direct-mapped, read-only instruction cache serving the fetch unit over the `ic_enable`/`iaddr`/`idata`/`ic_done` line-request interface. Each request returns one full 64-byte line. Misses are refilled from memory over a 64-bit beat bus with eight beats per line. The block sits between instruction fetch and the memory bus arbiter and has at most one outstanding request.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 32 +++
 rtl/icache.sv | 133 +++++++++++++
 tb/tb_icache.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and address-split helper for the instruction cache.
package icache_pkg;

  localparam int LINE_BYTES = 64;
  localparam int BEAT_BITS  = 64;
  localparam int BEATS      = 8;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFF_BITS   = 6;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESPOND} ic_state_t;

  typedef struct packed {
    logic [63:0] index;
    logic [63:0] tag;
  } ic_split_t;

  // idx_bits = log2(SETS); callers slice the fields down to their own widths.
  function automatic ic_split_t ic_split(input logic [63:0] addr, input int idx_bits);
    ic_split_t s;
    s.index = (addr >> OFF_BITS) & ((64'd1 << idx_bits) - 64'd1);
    s.tag   = addr >> (OFF_BITS + idx_bits);
    return s;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Synchronous-read line storage: SETS entries of {512-bit line, tag}. No reset;
// validity is tracked by the parent.
module icache_array import icache_pkg::*; #(
  parameter int SETS  = 64,
  parameter int TAG_W = 52
) (
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [$clog2(SETS)-1:0] rd_idx,
  output logic [LINE_BITS-1:0]    rd_data,
  output logic [TAG_W-1:0]        rd_tag,
  input  logic                    wr_en,
  input  logic [$clog2(SETS)-1:0] wr_idx,
  input  logic [LINE_BITS-1:0]    wr_data,
  input  logic [TAG_W-1:0]        wr_tag
);

  logic [LINE_BITS-1:0] data_mem [SETS];
  logic [TAG_W-1:0]     tag_mem  [SETS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
    if (rd_en) begin
      rd_data <= data_mem[rd_idx];
      rd_tag  <= tag_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; one 64-byte line per request,
// refilled over an eight-beat 64-bit memory bus.
module icache import icache_pkg::*; #(
  parameter int SETS = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_enable,
  input  logic [63:0]          iaddr,
  output logic [LINE_BITS-1:0] idata,
  output logic                 ic_done,
  input  logic                 flush,
  output logic                 mem_reqcyc,
  output logic [63:0]          mem_req,
  input  logic                 mem_reqack,
  input  logic                 mem_respcyc,
  input  logic [BEAT_BITS-1:0] mem_resp,
  output logic                 mem_respack
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 64 - OFF_BITS - IDX_W;

  ic_state_t                          state;
  logic [63-OFF_BITS:0]               line_q;
  logic [2:0]                         cnt;
  logic [SETS-1:0]                    valid;
  logic                               flush_pend;
  logic [BEATS-1:0][BEAT_BITS-1:0]    beat_buf, fill_line;
  ic_split_t                          rq_split, lk_split;
  logic [IDX_W-1:0]                   rq_idx, lk_idx;
  logic [TAG_W-1:0]                   lk_tag, rd_tag;
  logic [LINE_BITS-1:0]               rd_data;
  logic                               accept, hit, last_beat;
  logic                               split_unused;

  assign rq_split = ic_split(iaddr, IDX_W);
  assign lk_split = ic_split({line_q, {OFF_BITS{1'b0}}}, IDX_W);
  assign rq_idx   = rq_split.index[IDX_W-1:0];
  assign lk_idx   = lk_split.index[IDX_W-1:0];
  assign lk_tag   = lk_split.tag[TAG_W-1:0];
  assign split_unused = ^{rq_split.index[63:IDX_W], rq_split.tag,
                          lk_split.index[63:IDX_W], lk_split.tag[63:TAG_W],
                          iaddr[OFF_BITS-1:0]};

  // RESPOND is the ic_done cycle of a refill, so a new request is taken there too.
  assign accept      = ic_enable && (state == IDLE || state == RESPOND);
  assign hit         = valid[lk_idx] && (rd_tag == lk_tag);
  assign last_beat   = (state == FILL) && mem_respcyc && (cnt == 3'(BEATS - 1));
  assign mem_respack = mem_respcyc;

  // Complete line including the beat arriving this cycle.
  always_comb begin
    fill_line      = beat_buf;
    fill_line[cnt] = mem_resp;
  end

  icache_array #(.SETS(SETS), .TAG_W(TAG_W)) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (rq_idx),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .wr_en   (last_beat),
    .wr_idx  (lk_idx),
    .wr_data (fill_line),
    .wr_tag  (lk_tag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      line_q     <= '0;
      cnt        <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      beat_buf   <= '0;
      idata      <= '0;
      ic_done    <= 1'b0;
      mem_reqcyc <= 1'b0;
      mem_req    <= '0;
    end else begin
      ic_done <= 1'b0;
      if (flush) valid <= '0;
      // A flush that lands mid-miss must keep the fetched line from becoming valid.
      if (flush && (state == MISS_REQ || state == FILL)) flush_pend <= 1'b1;
      unique case (state)
        IDLE, RESPOND: begin
          if (accept) begin
            line_q <= iaddr[63:OFF_BITS];
            state  <= LOOKUP;
          end else begin
            state  <= IDLE;
          end
        end
        LOOKUP: begin
          flush_pend <= 1'b0;
          if (hit) begin
            idata   <= rd_data;
            ic_done <= 1'b1;
            state   <= IDLE;
          end else begin
            mem_reqcyc <= 1'b1;
            mem_req    <= {line_q, {OFF_BITS{1'b0}}};
            state      <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_reqack) begin
            mem_reqcyc <= 1'b0;
            cnt        <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (mem_respcyc) begin
            beat_buf[cnt] <= mem_resp;
            cnt           <= cnt + 3'd1;
            // Array write and line delivery commit on the final beat's edge.
            if (cnt == 3'(BEATS - 1)) begin
              idata   <= fill_line;
              ic_done <= 1'b1;
              state   <= RESPOND;
              if (!flush && !flush_pend) valid[lk_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written reset/flush
// sequences and a randomized phase against a line-granular residency model.
module tb_icache;
  import icache_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 ic_enable;
  logic [63:0]          iaddr;
  logic [LINE_BITS-1:0] idata;
  logic                 ic_done;
  logic                 flush;
  logic                 mem_reqcyc;
  logic [63:0]          mem_req;
  logic                 mem_reqack;
  logic                 mem_respcyc;
  logic [63:0]          mem_resp;
  logic                 mem_respack;

  icache #(.SETS(64)) dut (
    .clk(clk), .reset_n(reset_n), .ic_enable(ic_enable), .iaddr(iaddr),
    .idata(idata), .ic_done(ic_done), .flush(flush),
    .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqack(mem_reqack),
    .mem_respcyc(mem_respcyc), .mem_resp(mem_resp), .mem_respack(mem_respack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [511:0] last_line;
  logic [63:0]  res [int];   // index -> resident line address

  typedef struct {
    logic [63:0] addr;
    int          ack_dly;
    int          flush_beat;
    bit          exp_hit;
    int          max_gap;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_of(input logic [63:0] la, input int k);
    return {la[59:0], 4'(k)};
  endfunction

  function automatic logic [511:0] line_of(input logic [63:0] la);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_of(la, k);
    return l;
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 6) % 64);
  endfunction

  function automatic bit model_hit(input logic [63:0] a);
    logic [63:0] la;
    la = {a[63:6], 6'b0};
    return res.exists(idx_of(a)) && res[idx_of(a)] == la;
  endfunction

  // Issues one request starting in the current cycle; returns in the ic_done cycle.
  task automatic req(input logic [63:0] a, input int ack_dly, input int flush_beat,
                     input bit exp_hit, input int max_gap);
    logic [63:0]  la;
    logic [511:0] exp_line;
    int           gap;
    la       = {a[63:6], 6'b0};
    exp_line = line_of(la);
    iaddr = a; ic_enable = 1'b1;
    tick();
    ic_enable = 1'b0;
    chk("lookup_done_low", ic_done, 1'b0);
    chk("idata_hold", idata, last_line);
    tick();
    if (exp_hit) begin
      chk("hit_done", ic_done, 1'b1);
      chk("hit_data", idata, exp_line);
      chk("hit_no_reqcyc", mem_reqcyc, 1'b0);
    end else begin
      chk("miss_no_done", ic_done, 1'b0);
      chk("reqcyc_rise", mem_reqcyc, 1'b1);
      chk("req_addr", mem_req, la);
      for (int d = 0; d < ack_dly; d++) begin
        tick();
        chk("reqcyc_hold", mem_reqcyc, 1'b1);
        chk("req_addr_hold", mem_req, la);
      end
      mem_reqack = 1'b1;
      tick();
      mem_reqack = 1'b0;
      chk("reqcyc_drop", mem_reqcyc, 1'b0);
      for (int k = 0; k < 8; k++) begin
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) tick();
        mem_respcyc = 1'b1; mem_resp = beat_of(la, k); flush = (k == flush_beat);
        #1 chk("respack", mem_respack, 1'b1);
        tick();
        mem_respcyc = 1'b0; mem_resp = '0; flush = 1'b0;
        chk((k == 7) ? "fill_done" : "fill_no_done", ic_done, (k == 7));
      end
      chk("fill_data", idata, exp_line);
      if (flush_beat >= 0) res.delete();
      else res[idx_of(a)] = la;
    end
    last_line = exp_line;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h1000, 0, -1, 1'b0, 0};  // cold miss
    vecs[1] = '{64'h1023, 0, -1, 1'b1, 0};  // hit, offset ignored
    vecs[2] = '{64'h2000, 0, -1, 1'b0, 0};  // conflict, same index
    vecs[3] = '{64'h1000, 0, -1, 1'b0, 0};  // evicted line misses again
    vecs[4] = '{64'h3040, 5, -1, 1'b0, 3};  // delayed ack, irregular beats
    vecs[5] = '{64'h3040, 0, -1, 1'b1, 0};
    vecs[6] = '{64'h5080, 0,  3, 1'b0, 1};  // flush at beat 3
    vecs[7] = '{64'h5080, 0, -1, 1'b0, 0};  // not installed after flush
    vecs[8] = '{64'h5088, 0, -1, 1'b1, 0};

    reset_n = 1'b0; ic_enable = 1'b0; iaddr = '0; flush = 1'b0;
    mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
    last_line = '0;
    #1;
    chk("rst_done", ic_done, 1'b0);
    chk("rst_idata", idata, '0);
    chk("rst_reqcyc", mem_reqcyc, 1'b0);
    chk("rst_req", mem_req, '0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      req(vecs[i].addr, vecs[i].ack_dly, vecs[i].flush_beat, vecs[i].exp_hit, vecs[i].max_gap);

    // Reset in the middle of a refill: outputs clear at once, no ic_done follows.
    iaddr = 64'h7000; ic_enable = 1'b1;
    tick(); ic_enable = 1'b0;
    tick();
    chk("rst_seq_reqcyc", mem_reqcyc, 1'b1);
    mem_reqack = 1'b1; tick(); mem_reqack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_respcyc = 1'b1; mem_resp = beat_of(64'h7000, k);
      tick();
    end
    mem_respcyc = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_done", ic_done, 1'b0);
    chk("midrst_idata", idata, '0);
    chk("midrst_reqcyc", mem_reqcyc, 1'b0);
    chk("midrst_req", mem_req, '0);
    res.delete();
    last_line = '0;
    repeat (3) begin
      tick();
      chk("midrst_no_done", ic_done, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    req(64'h1000, 0, -1, 1'b0, 0);   // was resident before reset
    req(64'h7000, 1, -1, 1'b0, 2);
    req(64'h7030, 0, -1, 1'b1, 0);

    // Randomized traffic over a few colliding lines, with occasional flushes.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a;
      int fb;
      a = (64'($urandom_range(2, 0)) << 12) | (64'($urandom_range(3, 0)) << 6)
          | 64'($urandom_range(63, 0));
      fb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      if (model_hit(a)) req(a, 0, -1, 1'b1, 0);
      else req(a, int'($urandom_range(3, 0)), fb, 1'b0, 2);
      if ($urandom_range(9, 0) == 0) begin
        flush = 1'b1; tick(); flush = 1'b0;
        res.delete();
      end
    end
    tick();
    chk("final_done_low", ic_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
